io_step_controller: RTL and testbench

- Sequences the single-cycle MIPS core around its I/O opcodes: `in` (111000), `pause` (000111) and `print` (111111).
- Sits between the control unit's in/pause/print decode outputs and the PC/register-file enables.
- Stalls the core on `in` and `pause` until the operator presses a debounced confirm button.
- Captures switch data for `in` and latches `print` data for the display.

---
 rtl/io_step_controller.sv | 145 ++++++++++++++
 tb/tb_io_step_controller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_step_controller.sv
// io_step_controller
//   Sequences the single-cycle core around the I/O opcodes `in`, `pause` and
//   `print`. `in`/`pause` stall the core until a debounced confirm press;
//   `in` captures the switch bank into in_data_o and pulses in_wr_o for one
//   cycle in COMMIT. `print` latches print_data_i into display_o without a stall.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_i, pause_i,    decoded I/O opcodes from the control unit
//   print_i
//   print_data_i      register value to display
//   switches_i        raw asynchronous switch bank
//   confirm_btn_i     raw asynchronous pushbutton, active-high
//   stall_o           hold PC and suppress architectural writes
//   in_data_o         zero-extended captured switches
//   in_wr_o           one-cycle register-file write enable for in_data_o
//   display_o         last printed value
//   display_valid_o   set by the first print, cleared only by reset
//   state_o           FSM state for debug LEDs (RUN=0, WAIT_IN=1, WAIT_PAUSE=2, COMMIT=3)
module io_step_controller #(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_i,
    input  logic              pause_i,
    input  logic              print_i,
    input  logic [DATA_W-1:0] print_data_i,
    input  logic [SW_W-1:0]   switches_i,
    input  logic              confirm_btn_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] in_data_o,
    output logic              in_wr_o,
    output logic [DATA_W-1:0] display_o,
    output logic              display_valid_o,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_IN    = 2'd1,
        WAIT_PAUSE = 2'd2,
        COMMIT     = 2'd3
    } state_t;

    state_t            state;
    logic              btn_s1, btn_s2;
    logic [SW_W-1:0]   sw_s1, sw_s2;
    logic              btn_deb, btn_deb_q;
    logic [CNT_W-1:0]  db_cnt;
    logic              press_evt;
    logic              from_in;

    // Synchronizers and debounce. The counter only runs while the synced
    // button disagrees with the accepted level, so any bounce back restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_s1    <= confirm_btn_i;
            btn_s2    <= btn_s1;
            sw_s1     <= switches_i;
            sw_s2     <= sw_s1;
            btn_deb_q <= btn_deb;
            if (btn_s2 == btn_deb) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_deb <= ~btn_deb;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign press_evt = btn_deb & ~btn_deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            from_in         <= 1'b0;
            in_data_o       <= '0;
            display_o       <= '0;
            display_valid_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // Presses seen here are dropped; in > pause > print.
                    if (in_i) begin
                        state <= WAIT_IN;
                    end else if (pause_i) begin
                        state <= WAIT_PAUSE;
                    end else if (print_i) begin
                        display_o       <= print_data_i;
                        display_valid_o <= 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (press_evt) begin
                        in_data_o <= DATA_W'(sw_s2);
                        from_in   <= 1'b1;
                        state     <= COMMIT;
                    end
                end
                WAIT_PAUSE: begin
                    if (press_evt) begin
                        from_in <= 1'b0;
                        state   <= COMMIT;
                    end
                end
                COMMIT: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Stall is combinational in RUN so the PC never steps past in/pause.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            RUN:        stall_o = in_i | pause_i;
            WAIT_IN:    stall_o = 1'b1;
            WAIT_PAUSE: stall_o = 1'b1;
            default:    stall_o = 1'b0;
        endcase
    end

    assign in_wr_o = (state == COMMIT) && from_in;
    assign state_o = state;

endmodule

// File: tb/tb_io_step_controller.sv
module tb_io_step_controller;

    localparam int DW = 32;
    localparam int SW = 16;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_i = 1'b0;
    logic          pause_i = 1'b0;
    logic          print_i = 1'b0;
    logic [DW-1:0] print_data_i = '0;
    logic [SW-1:0] switches_i = '0;
    logic          confirm_btn_i = 1'b0;
    logic          stall_o;
    logic [DW-1:0] in_data_o;
    logic          in_wr_o;
    logic [DW-1:0] display_o;
    logic          display_valid_o;
    logic [1:0]    state_o;

    int checks = 0;
    int failures = 0;

    io_step_controller #(
        .DATA_W(DW),
        .SW_W(SW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_i(in_i),
        .pause_i(pause_i),
        .print_i(print_i),
        .print_data_i(print_data_i),
        .switches_i(switches_i),
        .confirm_btn_i(confirm_btn_i),
        .stall_o(stall_o),
        .in_data_o(in_data_o),
        .in_wr_o(in_wr_o),
        .display_o(display_o),
        .display_valid_o(display_valid_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: synced values are raw samples two edges old; the
    // accepted button level flips once the last DB synced samples all
    // disagree with it; a press is seen one edge after a rising flip.
    int            m_state;
    bit            m_from_in;
    logic [DW-1:0] m_in_data;
    logic [DW-1:0] m_disp;
    bit            m_valid;
    bit            m_deb;
    bit            m_rise;
    bit            btn_q[$];
    logic [SW-1:0] sw_q[$];
    bit            s_win[$];

    function automatic void model_reset();
        m_state   = 0;
        m_from_in = 1'b0;
        m_in_data = '0;
        m_disp    = '0;
        m_valid   = 1'b0;
        m_deb     = 1'b0;
        m_rise    = 1'b0;
        btn_q     = '{1'b0, 1'b0};
        sw_q      = '{16'h0, 16'h0};
        s_win.delete();
    endfunction

    function automatic void model_edge();
        bit            s;
        bit            press;
        bit            all_diff;
        logic [SW-1:0] sws;
        s   = btn_q.pop_front();
        btn_q.push_back(confirm_btn_i);
        sws = sw_q.pop_front();
        sw_q.push_back(switches_i);
        press = m_rise;
        case (m_state)
            0: begin
                if (in_i) m_state = 1;
                else if (pause_i) m_state = 2;
                else if (print_i) begin
                    m_disp  = print_data_i;
                    m_valid = 1'b1;
                end
            end
            1: if (press) begin
                m_in_data = {16'h0, sws};
                m_from_in = 1'b1;
                m_state   = 3;
            end
            2: if (press) begin
                m_from_in = 1'b0;
                m_state   = 3;
            end
            default: m_state = 0;
        endcase
        s_win.push_back(s);
        if (s_win.size() > DB) void'(s_win.pop_front());
        all_diff = (s_win.size() == DB);
        foreach (s_win[i]) if (s_win[i] == m_deb) all_diff = 1'b0;
        m_rise = all_diff && !m_deb;
        if (all_diff) m_deb = ~m_deb;
    endfunction

    task automatic compare_all();
        bit exp_stall;
        exp_stall = (m_state == 0) ? (in_i | pause_i) : (m_state == 1 || m_state == 2);
        check("state", 32'(state_o), 32'(m_state));
        check("stall", 32'(stall_o), 32'(exp_stall));
        check("in_wr", 32'(in_wr_o), 32'(m_state == 3 && m_from_in));
        check("in_data", in_data_o, m_in_data);
        check("display", display_o, m_disp);
        check("display_valid", 32'(display_valid_o), 32'(m_valid));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge();
        compare_all();
    endtask

    task automatic reset_mid();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_in_wr", 32'(in_wr_o), 32'd0);
        check("rst_in_data", in_data_o, 32'd0);
        check("rst_display", display_o, 32'd0);
        check("rst_valid", 32'(display_valid_o), 32'd0);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] target, input int limit);
        int n = 0;
        while (state_o !== target && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(state_o), 32'(target));
    endtask

    task automatic release_btn();
        confirm_btn_i = 1'b0;
        repeat (DB + 4) step();
    endtask

    initial begin
        int hold;
        int pulses;
        int commit_at;
        model_reset();

        // Reset and idle
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_stall", 32'(stall_o), 32'd0);
        end

        // `in` capture with a clean press
        switches_i = 16'hA5A5;
        repeat (3) step();
        in_i = 1'b1;
        #1;
        check("in_first_stall", 32'(stall_o), 32'd1);
        step();
        check("in_wait_state", 32'(state_o), 32'd1);
        confirm_btn_i = 1'b1;
        repeat (6) step();
        check("in_t6_state", 32'(state_o), 32'd1);
        step();
        check("in_t7_state", 32'(state_o), 32'd3);
        check("in_t7_wr", 32'(in_wr_o), 32'd1);
        check("in_t7_data", in_data_o, 32'h0000_A5A5);
        check("in_t7_stall", 32'(stall_o), 32'd0);
        in_i = 1'b0;
        step();
        check("in_t8_state", 32'(state_o), 32'd0);
        release_btn();

        // Bounce rejection in WAIT_IN
        in_i = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            confirm_btn_i = 1'b1;
            step();
            confirm_btn_i = 1'b0;
            step();
        end
        check("bounce_still_wait", 32'(state_o), 32'd1);
        confirm_btn_i = 1'b1;
        pulses = 0;
        commit_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (in_wr_o === 1'b1) pulses++;
            if (state_o === 2'd3 && commit_at == 0) begin
                commit_at = i;
                in_i = 1'b0;
            end
        end
        check("bounce_commit_at", 32'(commit_at), 32'd7);
        check("bounce_pulses", 32'(pulses), 32'd1);
        release_btn();

        // `pause` resume leaves in_data untouched
        switches_i = 16'h1234;
        pause_i = 1'b1;
        step();
        check("pause_state", 32'(state_o), 32'd2);
        check("pause_stall", 32'(stall_o), 32'd1);
        confirm_btn_i = 1'b1;
        wait_state("pause_commit", 2'd3, 12);
        check("pause_in_wr", 32'(in_wr_o), 32'd0);
        check("pause_in_data", in_data_o, 32'h0000_A5A5);
        pause_i = 1'b0;
        step();
        check("pause_back_run", 32'(state_o), 32'd0);
        release_btn();

        // `print` latch, then in+print together
        print_i = 1'b1;
        print_data_i = 32'hDEAD_BEEF;
        #1;
        check("print_no_stall", 32'(stall_o), 32'd0);
        step();
        check("print_display", display_o, 32'hDEAD_BEEF);
        check("print_valid", 32'(display_valid_o), 32'd1);
        in_i = 1'b1;
        print_data_i = 32'h1;
        step();
        check("in_print_display", display_o, 32'hDEAD_BEEF);
        check("in_print_state", 32'(state_o), 32'd1);
        print_i = 1'b0;
        confirm_btn_i = 1'b1;
        wait_state("in_print_commit", 2'd3, 12);
        in_i = 1'b0;
        step();
        release_btn();

        // Button held across the RUN->WAIT_IN transition
        confirm_btn_i = 1'b1;
        repeat (DB + 4) step();
        in_i = 1'b1;
        repeat (12) step();
        check("held_no_commit", 32'(state_o), 32'd1);
        release_btn();
        check("held_release_wait", 32'(state_o), 32'd1);
        confirm_btn_i = 1'b1;
        wait_state("held_repress", 2'd3, 12);
        in_i = 1'b0;
        step();
        release_btn();

        // Reset abort from WAIT_IN with a press in progress
        in_i = 1'b1;
        step();
        check("abort_wait", 32'(state_o), 32'd1);
        confirm_btn_i = 1'b1;
        repeat (3) step();
        reset_mid();
        in_i = 1'b0;
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (in_wr_o === 1'b1) pulses++;
        end
        check("abort_no_wr", 32'(pulses), 32'd0);
        release_btn();

        // Randomized traffic against the model
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                confirm_btn_i = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            in_i    = ($urandom_range(0, 11) == 0);
            pause_i = ($urandom_range(0, 11) == 0);
            print_i = ($urandom_range(0, 3) == 0);
            print_data_i = $urandom;
            if ($urandom_range(0, 3) == 0) switches_i = 16'($urandom);
            if (n == 1500) begin
                reset_mid();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
